s100_wait_gen: RTL

//  S100 bus wait-state generator. Consumes the latched cycle-start flag produced by the

---
 rtl/s100_pkg.sv | 15 +
 rtl/s100_wait_cnt.sv | 29 ++
 rtl/s100_wait_gen.sv | 119 +++++++++++
 3 files changed

// File: rtl/s100_pkg.sv
// Shared S100 bus-side definitions: wait-state FSM encoding and default wait constants.
package s100_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2,
    ST_HOLD = 2'd3
  } state_e;

  localparam int DEF_CNT_W    = 4;
  localparam int DEF_IO_WAIT  = 4;
  localparam int DEF_MEM_WAIT = 1;

endpackage

// File: rtl/s100_wait_cnt.sv
// Loadable down-counter for wait-state timing; saturates at zero instead of wrapping.
module s100_wait_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_val,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_is_one
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_cnt    = r_cnt;
  assign o_is_one = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/s100_wait_gen.sv
// S100 wait-state generator: holds RDY low for a per-target number of clocks after pSYNC,
// then pulses clr_n back to the pSYNC latch and waits for the bus strobes to go idle.
module s100_wait_gen
  import s100_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int IO_WAIT  = DEF_IO_WAIT,
  parameter int MEM_WAIT = DEF_MEM_WAIT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sync_q,
  input  logic cs_io,
  input  logic cs_mem,
  input  logic pdbin,
  input  logic pwr_n,
  output logic rdy,
  output logic clr_n,
  output logic busy
);

  if ((IO_WAIT > (2**CNT_W) - 1) || (MEM_WAIT > (2**CNT_W) - 1)) begin : g_param_chk
    $error("s100_wait_gen: IO_WAIT/MEM_WAIT does not fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] IO_N  = CNT_W'(IO_WAIT);
  localparam logic [CNT_W-1:0] MEM_N = CNT_W'(MEM_WAIT);

  state_e           r_state;
  state_e           w_state_nxt;
  logic             r_rdy;
  logic             r_clr_n;
  logic             r_busy;
  logic             w_rdy_nxt;
  logic             w_clr_n_nxt;
  logic             w_load;
  logic             w_dec;
  logic [CNT_W-1:0] w_n;
  logic [CNT_W-1:0] w_cnt;
  logic             w_is_one;
  logic             w_bus_idle;

  // cs_io has priority when both selects are asserted
  assign w_n        = cs_io ? IO_N : (cs_mem ? MEM_N : '0);
  assign w_bus_idle = !sync_q && !pdbin && pwr_n;

  s100_wait_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_load   (w_load),
    .i_val    (w_n),
    .i_dec    (w_dec),
    .o_cnt    (w_cnt),
    .o_is_one (w_is_one)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_rdy_nxt   = r_rdy;
    w_clr_n_nxt = 1'b1;
    w_load      = 1'b0;
    w_dec       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (sync_q) begin
          if (w_n != '0) begin
            w_load      = 1'b1;
            w_rdy_nxt   = 1'b0;
            w_state_nxt = ST_WAIT;
          end else begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_WAIT: begin
        w_dec = 1'b1;
        // A zero count here can only follow a glitch; release RDY rather than stall the bus
        if (w_is_one || (w_cnt == '0)) begin
          w_rdy_nxt   = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_clr_n_nxt = 1'b0;
        w_state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (w_bus_idle) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_rdy_nxt   = 1'b1;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_rdy   <= 1'b1;
      r_clr_n <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rdy   <= w_rdy_nxt;
      r_clr_n <= w_clr_n_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
    end
  end

  assign rdy   = r_rdy;
  assign clr_n = r_clr_n;
  assign busy  = r_busy;

endmodule
